dmem_rmw_ctrl: RTL and testbench
================================

# dmem_rmw_ctrl

Data-memory controller directly downstream of the MEM stage. It accepts MEM's data-memory request (address, write data, size, read/write strobes) and drives a single-port synchronous word SRAM. Sub-word stores are performed as a read-modify-write sequence. Loads and sub-word stores stall the pipeline until the access completes.

## Interface
Parameters:
- WADDR_W, default 14: SRAM word-address width; word address = data_address_IN[WADDR_W+1:2].
- RESET_DATA, default 32'h0: reset value of data_read_OUT.

Ports:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- MemRead_IN  in  1  load request from MEM.
- MemWrite_IN  in  1  store request from MEM.
- data_address_IN  in  32  byte address.
- data_write_IN  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- data_write_size_IN  in  2  0=word, 1=byte, 2=half, 3=reserved (treated as word).
- data_read_OUT  out  32  full aligned word returned for loads.
- STALL_OUT  out  1  MEM and upstream stages must hold while high.
- MISALIGN_OUT  out  1  misaligned access flag; present only with DMEM_MISALIGN_TRAP_EN.
- sram_en  out  1  SRAM enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  WADDR_W  SRAM word address.
- sram_wdata  out  32  SRAM write word.
- sram_rdata  in  32  SRAM read word, valid one cycle after an enabled read.

## Operation
- Byte lanes are big-endian: offset 0 maps to bits [31:24], offset 3 maps to bits [7:0]. Halfword at offset 0 maps to [31:16], offset 2 maps to [15:0].
- States: IDLE, LD_WAIT, RMW.
- In IDLE with MemWrite_IN and size word: sram_en=1, sram_we=1, sram_wdata=data_write_IN. Stays in IDLE; STALL_OUT=0.
- In IDLE with MemWrite_IN and size byte/half:
  - Issues a read (en=1, we=0); STALL_OUT=1.
  - Latches address offset, size and lane data; goes to RMW.
- In RMW:
  - sram_wdata = sram_rdata with the selected lane(s) replaced; en=1, we=1, same address.
  - STALL_OUT=0; returns to IDLE.
- In IDLE with MemRead_IN (and no MemWrite_IN): issues a read; STALL_OUT=1; goes to LD_WAIT.
- In LD_WAIT: data_read_OUT is loaded from sram_rdata at the cycle's edge. Combinationally, data_read_OUT passes sram_rdata during LD_WAIT. STALL_OUT=0; returns to IDLE.
- MemRead_IN and MemWrite_IN together: the store is performed and the load is ignored.
- No request: en=0, we=0, STALL_OUT=0.
- Halfword at odd offset without the macro: bit 0 of the address is ignored.
- sram_addr is combinational from data_address_IN in IDLE and from the latched address in LD_WAIT/RMW. MEM holds its inputs while stalled, but the latched copy governs.

## Timing
- Word store: 0 stall cycles; the write commits at the end of the request cycle.
- Load: 1 stall cycle; data_read_OUT is valid in the second cycle (LD_WAIT) and holds thereafter until the next load.
- Sub-word store: 1 stall cycle; the merged word commits at the end of the RMW cycle.
- Reset values: state=IDLE, data_read_OUT=RESET_DATA, STALL_OUT=0, MISALIGN_OUT=0, sram_en=0, sram_we=0.
- Reset asserted mid-RMW or mid-LD_WAIT: the pending write is dropped and never issued, and the SRAM contents are unchanged. All outputs return to their reset values immediately (asynchronous).
- Back-to-back requests: a new request is accepted in the IDLE cycle directly following LD_WAIT/RMW. There are no bubbles beyond those listed above.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - Misaligned accesses are a word at offset ≠0 or a half at an odd offset.
  - Such an access raises MISALIGN_OUT for exactly one cycle (the request cycle).
  - The SRAM write is suppressed, a load returns 32'h0, and the state stays IDLE with no stall.
- Not defined: the MISALIGN_OUT port is absent. Offsets are truncated: words are forced to offset 0 and halves to offset & 2.

## Structure
- Shared package holds:
  - size encodings SZ_WORD=0, SZ_BYTE=1, SZ_HALF=2;
  - the state enum {IDLE, LD_WAIT, RMW}.
- One sub-module, dmem_lane_merge: a combinational function of (old word, new data, size, offset) that returns the merged word. It is reused by any future store-buffer block.

## Test plan
- Word store 32'hDEADBEEF to 0x100, then load 0x100: no stall on the store, one stall cycle on the load, data_read_OUT=32'hDEADBEEF.
- Memory 0x100=32'h11223344; store byte 0xAA at 0x102: STALL_OUT high 1 cycle, memory becomes 32'h1122AA44.
- Memory 0x100=32'h11223344; store half 0xBEEF at 0x100: memory becomes 32'hBEEF3344. Half 0xCAFE at 0x102 then gives 32'hBEEFCAFE.
- Simultaneous MemRead_IN and MemWrite_IN, word 32'h5 to 0x40: memory becomes 5, no stall, data_read_OUT unchanged.
- RESET pulsed during the RMW cycle of a byte store to 0x100: memory still 32'h11223344, STALL_OUT=0, state IDLE.
- With DMEM_MISALIGN_TRAP_EN: word store to 0x101 gives MISALIGN_OUT=1 for one cycle, no SRAM write. Without the macro, the same store writes word 0x100.

Source files
------------

// File: rtl/dmem_rmw_ctrl_pkg.sv
// Shared encodings for the data-memory read-modify-write controller:
// access sizes, controller states and a sub-word size helper.
package dmem_rmw_ctrl_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        RMW     = 2'd2
    } dmem_state_e;

    // Size code 3 is reserved and behaves like a full word.
    function automatic logic is_subword(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational big-endian lane merge: replaces the byte or halfword lane
// selected by offset in old_word with the right-justified new_data.
module dmem_lane_merge
    import dmem_rmw_ctrl_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] merged_word
);

    always_comb begin
        merged_word = old_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merged_word[31:24] = new_data[7:0];
                    2'd1:    merged_word[23:16] = new_data[7:0];
                    2'd2:    merged_word[15:8]  = new_data[7:0];
                    default: merged_word[7:0]   = new_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1])
                    merged_word[15:0] = new_data[15:0];
                else
                    merged_word[31:16] = new_data[15:0];
            end
            default: merged_word = new_data;
        endcase
    end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory controller between MEM and a single-port synchronous SRAM.
// Sub-word stores use read-modify-write; DMEM_MISALIGN_TRAP_EN enables misalignment trapping.
module dmem_rmw_ctrl
    import dmem_rmw_ctrl_pkg::*;
#(
    parameter int          WADDR_W    = 14,
    parameter logic [31:0] RESET_DATA = 32'h0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               MemRead_IN,
    input  logic               MemWrite_IN,
    input  logic [31:0]        data_address_IN,
    input  logic [31:0]        data_write_IN,
    input  logic [1:0]         data_write_size_IN,
    output logic [31:0]        data_read_OUT,
    output logic               STALL_OUT,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic               MISALIGN_OUT,
`endif
    output logic               sram_en,
    output logic               sram_we,
    output logic [WADDR_W-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_LD_WAIT = 2'(LD_WAIT);
    localparam logic [1:0] ST_RMW     = 2'(RMW);

    logic [1:0]         state, state_nxt;
    logic [WADDR_W-1:0] addr_q;
    logic [1:0]         off_q;
    logic [1:0]         size_q;
    logic [31:0]        data_q;
    logic [31:0]        read_q;

    logic [WADDR_W-1:0] req_addr;
    logic [1:0]         req_off;
    logic               req_sub;
    logic               misalign;
    logic               mis_flag;
    logic               ld_zero;
    logic               en_c, we_c, stall_c;
    logic [31:0]        merged_word;
    logic               unused_addr_hi;

    assign req_addr       = data_address_IN[WADDR_W+1:2];
    assign req_sub        = is_subword(data_write_size_IN);
    assign unused_addr_hi = ^data_address_IN[31:WADDR_W+2];

    // Without trapping, halves drop address bit 0; words ignore the offset entirely.
    assign req_off = (data_write_size_IN == SZ_HALF) ? {data_address_IN[1], 1'b0}
                                                     : data_address_IN[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = (!req_sub && (data_address_IN[1:0] != 2'd0)) ||
                      ((data_write_size_IN == SZ_HALF) && data_address_IN[0]);
`else
    assign misalign = 1'b0;
`endif

    dmem_lane_merge u_lane_merge (
        .old_word    (sram_rdata),
        .new_data    (data_q),
        .size        (size_q),
        .offset      (off_q),
        .merged_word (merged_word)
    );

    always_comb begin
        state_nxt     = state;
        en_c          = 1'b0;
        we_c          = 1'b0;
        stall_c       = 1'b0;
        mis_flag      = 1'b0;
        ld_zero       = 1'b0;
        sram_addr     = req_addr;
        sram_wdata    = data_write_IN;
        data_read_OUT = read_q;
        case (state)
            ST_IDLE: begin
                if (MemWrite_IN) begin
                    if (misalign) begin
                        mis_flag = 1'b1;
                    end else if (req_sub) begin
                        en_c      = 1'b1;
                        stall_c   = 1'b1;
                        state_nxt = ST_RMW;
                    end else begin
                        en_c = 1'b1;
                        we_c = 1'b1;
                    end
                end else if (MemRead_IN) begin
                    if (misalign) begin
                        mis_flag = 1'b1;
                        ld_zero  = 1'b1;
                    end else begin
                        en_c      = 1'b1;
                        stall_c   = 1'b1;
                        state_nxt = ST_LD_WAIT;
                    end
                end
            end
            ST_LD_WAIT: begin
                sram_addr     = addr_q;
                data_read_OUT = sram_rdata;
                state_nxt     = ST_IDLE;
            end
            ST_RMW: begin
                sram_addr  = addr_q;
                sram_wdata = merged_word;
                en_c       = 1'b1;
                we_c       = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset forces the SRAM strobes low at once so a pending RMW write is dropped.
    assign sram_en   = en_c & ~RESET;
    assign sram_we   = we_c & ~RESET;
    assign STALL_OUT = stall_c & ~RESET;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign MISALIGN_OUT = mis_flag & ~RESET;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            off_q  <= 2'd0;
            size_q <= SZ_WORD;
            data_q <= 32'h0;
            read_q <= RESET_DATA;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt != ST_IDLE) begin
                addr_q <= req_addr;
                off_q  <= req_off;
                size_q <= data_write_size_IN;
                data_q <= data_write_IN;
            end
            if (state == ST_LD_WAIT)
                read_q <= sram_rdata;
            else if (ld_zero)
                read_q <= 32'h0;
        end
    end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Scoreboard bench for dmem_rmw_ctrl with a behavioural SRAM model;
// honours DMEM_MISALIGN_TRAP_EN for the misaligned-access expectations.
module tb_dmem_rmw_ctrl;

    localparam int WADDR_W = 14;

    typedef struct {
        logic [WADDR_W-1:0] addr;
        logic [31:0]        data;
    } wr_exp_t;

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               MemRead_IN = 1'b0;
    logic               MemWrite_IN = 1'b0;
    logic [31:0]        data_address_IN = 32'h0;
    logic [31:0]        data_write_IN = 32'h0;
    logic [1:0]         data_write_size_IN = 2'd0;
    logic [31:0]        data_read_OUT;
    logic               STALL_OUT;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic               MISALIGN_OUT;
`endif
    logic               sram_en;
    logic               sram_we;
    logic [WADDR_W-1:0] sram_addr;
    logic [31:0]        sram_wdata;
    logic [31:0]        sram_rdata = 32'h0;

    logic [31:0]        mem [0:(1<<WADDR_W)-1];
    wr_exp_t            wrQ[$];
    logic [31:0]        ldQ[$];
    int                 vecCount = 0;
    int                 missCount = 0;
    logic               loadIssued = 1'b0;

    dmem_rmw_ctrl #(.WADDR_W(WADDR_W), .RESET_DATA(32'h0)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .MemRead_IN         (MemRead_IN),
        .MemWrite_IN        (MemWrite_IN),
        .data_address_IN    (data_address_IN),
        .data_write_IN      (data_write_IN),
        .data_write_size_IN (data_write_size_IN),
        .data_read_OUT      (data_read_OUT),
        .STALL_OUT          (STALL_OUT),
`ifdef DMEM_MISALIGN_TRAP_EN
        .MISALIGN_OUT       (MISALIGN_OUT),
`endif
        .sram_en            (sram_en),
        .sram_we            (sram_we),
        .sram_addr          (sram_addr),
        .sram_wdata         (sram_wdata),
        .sram_rdata         (sram_rdata)
    );

    always #5 CLK = ~CLK;

    // Read-first synchronous SRAM.
    always @(posedge CLK) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            sram_rdata <= mem[sram_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: pops expected SRAM writes and load results as the DUT presents them.
    always @(negedge CLK) begin
        if (loadIssued) begin
            if (ldQ.size() == 0)
                checkOutput("load_unexpected", 32'd1, 32'd0);
            else
                checkOutput("load_data", data_read_OUT, ldQ.pop_front());
        end
        loadIssued = !RESET && MemRead_IN && !MemWrite_IN && STALL_OUT;
        if (sram_en && sram_we) begin
            if (wrQ.size() == 0) begin
                checkOutput("write_unexpected", {18'h0, sram_addr}, 32'hFFFFFFFF);
            end else begin
                wr_exp_t e;
                e = wrQ.pop_front();
                checkOutput("write_addr", {18'h0, sram_addr}, {18'h0, e.addr});
                checkOutput("write_data", sram_wdata, e.data);
            end
        end
    end

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size,
                                 input logic expStall);
        @(posedge CLK);
        #1;
        MemRead_IN         = rd;
        MemWrite_IN        = wr;
        data_address_IN    = addr;
        data_write_IN      = wdata;
        data_write_size_IN = size;
        @(negedge CLK);
        checkOutput("stall", {31'h0, STALL_OUT}, {31'h0, expStall});
    endtask

    task automatic pushWrite(input logic [31:0] byteAddr, input logic [31:0] data);
        wr_exp_t e;
        e.addr = byteAddr[WADDR_W+1:2];
        e.data = data;
        wrQ.push_back(e);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    endtask

    task automatic wordStore(input logic [31:0] addr, input logic [31:0] data);
        pushWrite(addr, data);
        applyStimulus(1'b0, 1'b1, addr, data, 2'd0, 1'b0);
    endtask

    task automatic subStore(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] size, input logic [31:0] expWord);
        pushWrite(addr, expWord);
        applyStimulus(1'b0, 1'b1, addr, data, size, 1'b1);
        applyStimulus(1'b0, 1'b1, addr, data, size, 1'b0);
    endtask

    task automatic loadCheck(input logic [31:0] addr, input logic [31:0] exp);
        ldQ.push_back(exp);
        applyStimulus(1'b1, 1'b0, addr, 32'h0, 2'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, addr, 32'h0, 2'd0, 1'b0);
        idleCycle();
        checkOutput("load_hold", data_read_OUT, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3;
        checkOutput("reset_read", data_read_OUT, 32'h0);
        checkOutput("reset_stall", {31'h0, STALL_OUT}, 32'h0);
        checkOutput("reset_en", {31'h0, sram_en}, 32'h0);
        checkOutput("reset_we", {31'h0, sram_we}, 32'h0);
        @(posedge CLK);
        #1 RESET = 1'b0;

        $display("[TB] word store then load");
        wordStore(32'h100, 32'hDEADBEEF);
        loadCheck(32'h100, 32'hDEADBEEF);

        $display("[TB] byte store at offset 2");
        wordStore(32'h100, 32'h11223344);
        subStore(32'h102, 32'h000000AA, 2'd1, 32'h1122AA44);
        loadCheck(32'h100, 32'h1122AA44);

        $display("[TB] half stores back to back");
        wordStore(32'h100, 32'h11223344);
        subStore(32'h100, 32'h0000BEEF, 2'd2, 32'hBEEF3344);
        subStore(32'h102, 32'h0000CAFE, 2'd2, 32'hBEEFCAFE);
        loadCheck(32'h100, 32'hBEEFCAFE);

        $display("[TB] byte stores at lane boundaries");
        subStore(32'h103, 32'hFFFFFF55, 2'd1, 32'hBEEFCA55);
        subStore(32'h100, 32'h00000066, 2'd1, 32'h66EFCA55);
        loadCheck(32'h100, 32'h66EFCA55);

        $display("[TB] simultaneous read and write");
        pushWrite(32'h40, 32'h5);
        applyStimulus(1'b1, 1'b1, 32'h40, 32'h5, 2'd0, 1'b0);
        idleCycle();
        checkOutput("rdwr_read_unchanged", data_read_OUT, 32'h66EFCA55);
        loadCheck(32'h40, 32'h5);

        $display("[TB] reserved size acts as word");
        pushWrite(32'h104, 32'hA5A5A5A5);
        applyStimulus(1'b0, 1'b1, 32'h104, 32'hA5A5A5A5, 2'd3, 1'b0);
        loadCheck(32'h104, 32'hA5A5A5A5);

        $display("[TB] reset during RMW");
        wordStore(32'h100, 32'h11223344);
        applyStimulus(1'b0, 1'b1, 32'h102, 32'h000000AA, 2'd1, 1'b1);
        @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        checkOutput("rst_rmw_stall", {31'h0, STALL_OUT}, 32'h0);
        checkOutput("rst_rmw_en", {31'h0, sram_en}, 32'h0);
        checkOutput("rst_rmw_read", data_read_OUT, 32'h0);
        @(posedge CLK);
        #1;
        RESET       = 1'b0;
        MemWrite_IN = 1'b0;
        @(negedge CLK);
        checkOutput("post_rst_stall", {31'h0, STALL_OUT}, 32'h0);
        loadCheck(32'h100, 32'h11223344);

        $display("[TB] misaligned accesses");
`ifdef DMEM_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 1'b1, 32'h101, 32'h12345678, 2'd0, 1'b0);
        checkOutput("mis_word_flag", {31'h0, MISALIGN_OUT}, 32'h1);
        idleCycle();
        checkOutput("mis_flag_clear", {31'h0, MISALIGN_OUT}, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h101, 32'h00007777, 2'd2, 1'b0);
        checkOutput("mis_half_flag", {31'h0, MISALIGN_OUT}, 32'h1);
        loadCheck(32'h100, 32'h11223344);
        applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, 2'd0, 1'b0);
        checkOutput("mis_load_flag", {31'h0, MISALIGN_OUT}, 32'h1);
        idleCycle();
        checkOutput("mis_load_zero", data_read_OUT, 32'h0);
`else
        wordStore(32'h101, 32'h12345678);
        loadCheck(32'h100, 32'h12345678);
        subStore(32'h101, 32'h00007777, 2'd2, 32'h77775678);
        loadCheck(32'h100, 32'h77775678);
`endif

        idleCycle();
        idleCycle();
        checkOutput("write_queue_empty", 32'(wrQ.size()), 32'd0);
        checkOutput("load_queue_empty", 32'(ldQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
